param_fifo: RTL
===============

PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, data word width in bits (>=1).
REQ-002 SHALL provide parameter DEPTH, default 8, number of entries (>=2, not required to be a power of two).
REQ-003 SHALL provide parameter AF_LEVEL, default DEPTH-2, occupancy at or above which almost_full asserts.
REQ-004 SHALL provide parameter AE_LEVEL, default 2, occupancy at or below which almost_empty asserts.
REQ-005 SHALL provide parameter FWFT, default 0; 0 selects registered-read mode, 1 selects first-word-fall-through mode.
REQ-006 SHALL provide port clk  input  1  single clock; all state changes on its rising edge.
REQ-007 SHALL provide port reset  input  1  asynchronous, active-high reset.
REQ-008 SHALL provide port wr_req  input  1  write request.
REQ-009 SHALL provide port data_in  input  WIDTH  write data.
REQ-010 SHALL provide port rd_req  input  1  read (pop) request.
REQ-011 SHALL provide port err_clr  input  1  synchronous clear of sticky error flags.
REQ-012 SHALL provide port data_out  output  WIDTH  read data.
REQ-013 SHALL provide ports full, empty, almost_full, almost_empty  output  1 each  status flags.
REQ-014 SHALL provide port count  output  $clog2(DEPTH+1)  current occupancy.
REQ-015 SHALL provide ports overflow, underflow  output  1 each  sticky error flags.

Function
REQ-016 SHALL accept a write when wr_req=1 and full=0; the write is rejected when full=1, even if a read is accepted in the same cycle.
REQ-017 SHALL accept a read when rd_req=1 and empty=0; the read is rejected when empty=1, even if a write is accepted in the same cycle.
REQ-018 SHALL update count +1 on write only, -1 on read only, unchanged on a simultaneous accepted write and read.
REQ-019 SHALL advance wr_ptr/rd_ptr by one per accepted operation, wrapping from DEPTH-1 to 0.
REQ-020 SHALL drive full=(count==DEPTH), empty=(count==0), almost_full=(count>=AF_LEVEL), almost_empty=(count<=AE_LEVEL), all decoded from registered count.
REQ-021 SHALL, with FWFT=0, register the head word into data_out on the clock edge of an accepted read (1-cycle latency) and hold data_out otherwise.
REQ-022 SHALL, with FWFT=1, present the head word on data_out whenever empty=0; an accepted read exposes the next entry in the following cycle; data_out is don't-care while empty=1.
REQ-023 SHALL make a written word readable no earlier than the cycle after its write edge (empty deasserts one cycle after the first write).
REQ-024 SHALL set overflow on any cycle with wr_req=1 and full=1, and underflow on any cycle with rd_req=1 and empty=1; both remain set until err_clr or reset.
REQ-025 SHALL give a set condition priority over err_clr in the same cycle.
REQ-026 SHALL leave memory and state unchanged by rejected requests.

Reset
REQ-027 SHALL, on reset assertion and without waiting for clk, clear pointers and count and drive data_out=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0.
REQ-028 SHALL not require memory contents to be cleared; contents are invalid after reset.
REQ-029 SHALL discard all in-flight operations when reset asserts mid-operation; the first accepted operation after release occurs on the first clk edge with reset=0.

Verification
REQ-030 SHALL pass: (WIDTH=8, DEPTH=8, FWFT=0) write 0x01..0x08 -> full=1, count=8, almost_full=1 from count=6; 8 reads -> data_out 0x01..0x08, each 1 cycle after its read edge; empty=1.
REQ-031 SHALL pass: full FIFO with wr_req=1, rd_req=1 for one cycle -> read accepted, write rejected, count=7, overflow=1; err_clr pulse -> overflow=0.
REQ-032 SHALL pass: count=4, wr_req=rd_req=1 for 20 cycles -> count stays 4, pointers wrap, output order equals input order.
REQ-033 SHALL pass: empty FIFO, wr_req=rd_req=1 with data_in=0xA5 -> write accepted, underflow=1, count=1; next read -> 0xA5.
REQ-034 SHALL pass: FWFT=1, write 0x3C into empty FIFO -> data_out=0x3C one cycle later with no read; read -> empty=1 next cycle.
REQ-035 SHALL pass: reset asserted between clock edges with count=5 -> count=0, empty=1, data_out=0 immediately, before the next clk edge.

Source files
------------

// File: rtl/param_fifo.sv
// param_fifo: parameterised single-clock FIFO with registered or first-word-fall-through read, level flags and sticky errors
module param_fifo #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_req,
    input  logic [WIDTH-1:0]           data_in,
    input  logic                       rd_req,
    input  logic                       err_clr,
    output logic [WIDTH-1:0]           data_out,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       underflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST    = PW'(DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic             wr_ok, rd_ok;

    // status flags decoded from the registered occupancy; a blocked side never moves state
    always_comb begin
        full         = count == DEPTH_C;
        empty        = count == '0;
        almost_full  = count >= AF_C;
        almost_empty = count <= AE_C;
        wr_ok        = wr_req && !full;
        rd_ok        = rd_req && !empty;
    end

    // pointers wrap at DEPTH-1 so non-power-of-two depths work; count nets out simultaneous ops
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
            count <= count + CW'(wr_ok) - CW'(rd_ok);
        end
    end

    // sticky errors: a new violation wins over a clear in the same cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= (wr_req && full) || (overflow && !err_clr);
            underflow <= (rd_req && empty) || (underflow && !err_clr);
        end
    end

    // storage is deliberately not reset; contents are meaningless until rewritten
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= data_in;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign data_out = empty ? '0 : mem[rd_ptr];
        end else begin : g_reg
            // registered read: head word captured on the edge of an accepted pop, held otherwise
            always_ff @(posedge clk or posedge reset) begin
                if (reset) data_out <= '0;
                else if (rd_ok) data_out <= mem[rd_ptr];
            end
        end
    endgenerate
endmodule
